// File: rtl/instr_imm_decoder.sv
// Instruction decode ahead of the sign extender: decodes each accepted word into
// immediate/ExtSel/register fields and holds up to two decoded entries in arrival order.
module instr_imm_decoder #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      imm_out,
  output logic [1:0]       ext_sel,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [5:0]       opcode,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef struct packed {
    logic [31:0] imm;
    logic [1:0]  ext_sel;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  opcode;
    logic        illegal;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam entry_t          RESET_ENTRY = '{32'd0, 2'b10, 5'd0, 5'd0, 5'd0, 6'd0, 1'b0};
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  function automatic entry_t decode(input logic [31:0] w);
    entry_t e;
    e.rs      = w[25:21];
    e.rt      = w[20:16];
    e.rd      = w[15:11];
    e.opcode  = w[31:26];
    e.imm     = 32'd0;
    e.ext_sel = 2'b10;
    e.illegal = 1'b0;
    case (w[31:26])
      6'h23, 6'h2B, 6'h08, 6'h09, 6'h0A, 6'h0B: begin
        e.ext_sel = 2'b00;
        e.imm     = {16'b0, w[15:0]};
      end
      6'h04, 6'h05: begin
        e.ext_sel = 2'b01;
        e.imm     = {16'b0, w[15:0]};
      end
      6'h02, 6'h03: begin
        e.ext_sel = 2'b11;
        e.imm     = {6'b0, w[25:0]};
      end
      6'h00:   e.illegal = 1'b0;
      default: e.illegal = 1'b1;
    endcase
    return e;
  endfunction

  state_t           state_q, state_d;
  entry_t           head_q, head_d;
  entry_t           tail_q, tail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  entry_t           dec;
  logic             push, pop;

  assign dec  = decode(instr);
  assign push = in_valid & in_ready_q;
  assign pop  = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      if (push && dec.illegal && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);
      case (state_q)
        EMPTY: begin
          if (push) begin
            head_d  = dec;
            state_d = ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_d = dec;
          end else if (push) begin
            tail_d  = dec;
            state_d = TWO;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            head_d  = tail_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    // Handshake flags are registered from the next state so in_ready never sees out_ready.
    in_ready_d  = (int'(state_d) < DEPTH);
    out_valid_d = (state_d != EMPTY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      head_q      <= RESET_ENTRY;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      head_q      <= head_d;
      cnt_q       <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    tail_q <= tail_d;
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign imm_out     = head_q.imm;
  assign ext_sel     = head_q.ext_sel;
  assign rs          = head_q.rs;
  assign rt          = head_q.rt;
  assign rd          = head_q.rd;
  assign opcode      = head_q.opcode;
  assign illegal     = head_q.illegal;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_instr_imm_decoder.sv
// Bench for instr_imm_decoder: directed handshake scenarios, a decode vector table and
// randomized traffic compared against a queue-based reference model.
module tb_instr_imm_decoder;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] instr;
  logic        in_ready, out_valid, illegal;
  logic [31:0] imm_out;
  logic [1:0]  ext_sel;
  logic [4:0]  rs, rt, rd;
  logic [5:0]  opcode;
  logic [15:0] illegal_cnt;

  instr_imm_decoder #(.DEPTH(2), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .imm_out(imm_out), .ext_sel(ext_sel), .rs(rs), .rt(rt), .rd(rd),
    .opcode(opcode), .illegal(illegal), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [1:0]  sel;
    logic        ill;
  } exp_t;

  exp_t        m_q[$];
  int unsigned m_cnt;

  function automatic exp_t ref_decode(input logic [31:0] w);
    exp_t e;
    int unsigned op;
    op      = w >> 26;
    e.instr = w;
    e.imm   = 32'd0;
    e.sel   = 2'b10;
    e.ill   = 1'b0;
    if (op inside {'h23, 'h2B, 'h08, 'h09, 'h0A, 'h0B}) begin
      e.sel = 2'b00;
      e.imm = w % 32'h10000;
    end else if (op inside {'h04, 'h05}) begin
      e.sel = 2'b01;
      e.imm = w % 32'h10000;
    end else if (op inside {'h02, 'h03}) begin
      e.sel = 2'b11;
      e.imm = w % 32'h0400_0000;
    end else if (op != 0) begin
      e.ill = 1'b1;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic check_model();
    exp_t hd;
    chk("in_ready", 32'(in_ready), (m_q.size() < 2) ? 32'd1 : 32'd0);
    chk("out_valid", 32'(out_valid), (m_q.size() > 0) ? 32'd1 : 32'd0);
    chk("illegal_cnt", 32'(illegal_cnt), m_cnt);
    if (m_q.size() > 0) begin
      hd = m_q[0];
      chk("imm_out", imm_out, hd.imm);
      chk("ext_sel", 32'(ext_sel), 32'(hd.sel));
      chk("illegal", 32'(illegal), 32'(hd.ill));
      chk("rs", 32'(rs), 32'(hd.instr[25:21]));
      chk("rt", 32'(rt), 32'(hd.instr[20:16]));
      chk("rd", 32'(rd), 32'(hd.instr[15:11]));
      chk("opcode", 32'(opcode), 32'(hd.instr[31:26]));
    end
  endtask

  task automatic tick();
    bit   push, pop;
    exp_t e;
    push = in_valid && (m_q.size() < 2);
    pop  = out_ready && (m_q.size() > 0);
    e    = ref_decode(instr);
    @(posedge clk);
    if (reset) begin
      m_q.delete();
      m_cnt = 0;
    end else if (flush) begin
      m_q.delete();
    end else begin
      if (push && e.ill && m_cnt < 65535) m_cnt++;
      if (pop) void'(m_q.pop_front());
      if (push) m_q.push_back(e);
    end
    #1;
    check_model();
  endtask

  task automatic check_reset_vals();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_imm", imm_out, 32'd0);
    chk("rst_ext_sel", 32'(ext_sel), 32'd2);
    chk("rst_rs", 32'(rs), 32'd0);
    chk("rst_rt", 32'(rt), 32'd0);
    chk("rst_rd", 32'(rd), 32'd0);
    chk("rst_opcode", 32'(opcode), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_cnt", 32'(illegal_cnt), 32'd0);
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [1:0]  sel;
    logic        ill;
  } vec_t;

  vec_t        vecs[10];
  logic [5:0]  ops[11];
  logic [31:0] r;

  initial begin
    vecs[0] = '{32'h8C22FFFC, 32'h0000FFFC, 2'b00, 1'b0};
    vecs[1] = '{32'hAC438000, 32'h00008000, 2'b00, 1'b0};
    vecs[2] = '{32'h2001FFFF, 32'h0000FFFF, 2'b00, 1'b0};
    vecs[3] = '{32'h24211234, 32'h00001234, 2'b00, 1'b0};
    vecs[4] = '{32'h2841000A, 32'h0000000A, 2'b00, 1'b0};
    vecs[5] = '{32'h2C41FFF0, 32'h0000FFF0, 2'b00, 1'b0};
    vecs[6] = '{32'h1443FFFD, 32'h0000FFFD, 2'b01, 1'b0};
    vecs[7] = '{32'h0FFFFFFF, 32'h03FFFFFF, 2'b11, 1'b0};
    vecs[8] = '{32'h00430820, 32'h00000000, 2'b10, 1'b0};
    vecs[9] = '{32'h3C011234, 32'h00000000, 2'b10, 1'b1};
    ops = '{6'h23, 6'h2B, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h04, 6'h05, 6'h02, 6'h03, 6'h00};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = 32'd0;
    m_cnt = 0;
    tick();
    reset = 1'b0;
    check_reset_vals();

    // lw into EMPTY is visible the next cycle
    in_valid = 1'b1; instr = 32'h8C22FFFC; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_sel", 32'(ext_sel), 32'd0);
    chk("t1_imm", imm_out, 32'h0000FFFC);
    chk("t1_rs", 32'(rs), 32'd1);
    chk("t1_rt", 32'(rt), 32'd2);
    tick();
    chk("t1_drain", 32'(out_valid), 32'd0);

    // fill to TWO with out_ready low
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'h1022FFFE;
    tick();
    instr = 32'h08000010;
    tick();
    in_valid = 1'b0;
    chk("t2_in_ready", 32'(in_ready), 32'd0);
    chk("t2_head0_sel", 32'(ext_sel), 32'd1);
    chk("t2_head0_imm", imm_out, 32'h0000FFFE);
    tick();
    chk("t2_hold_imm", imm_out, 32'h0000FFFE);

    // in TWO: pop with in_valid high takes nothing new
    out_ready = 1'b1; in_valid = 1'b1; instr = 32'h20010005;
    tick();
    out_ready = 1'b0; in_valid = 1'b0;
    chk("t3_in_ready", 32'(in_ready), 32'd1);
    chk("t3_head1_sel", 32'(ext_sel), 32'd3);
    chk("t3_head1_imm", imm_out, 32'h00000010);
    out_ready = 1'b1;
    tick();
    chk("t3_empty", 32'(out_valid), 32'd0);

    // flush in ONE with a simultaneous illegal push
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'h8C22FFFC;
    tick();
    flush = 1'b1; instr = 32'hFC000000;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("t5_valid", 32'(out_valid), 32'd0);
    chk("t5_in_ready", 32'(in_ready), 32'd1);
    chk("t5_cnt", 32'(illegal_cnt), 32'd0);

    // illegal opcode and counter saturation
    in_valid = 1'b1; out_ready = 1'b1; instr = 32'hFC000000;
    tick();
    chk("t4_illegal", 32'(illegal), 32'd1);
    chk("t4_sel", 32'(ext_sel), 32'd2);
    chk("t4_imm", imm_out, 32'd0);
    chk("t4_cnt1", 32'(illegal_cnt), 32'd1);
    for (int i = 0; i < 65533; i++) tick();
    chk("t4_cnt_maxm1", 32'(illegal_cnt), 32'h0000FFFE);
    tick();
    chk("t4_cnt_max", 32'(illegal_cnt), 32'h0000FFFF);
    tick();
    chk("t4_cnt_sat", 32'(illegal_cnt), 32'h0000FFFF);

    // reset during a push/pop cycle
    reset = 1'b1;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    check_reset_vals();
    in_valid = 1'b1; instr = 32'h00221820;
    tick();
    in_valid = 1'b0;
    chk("t6_sel", 32'(ext_sel), 32'd2);
    chk("t6_imm", imm_out, 32'd0);
    chk("t6_rd", 32'(rd), 32'd3);
    tick();

    // decode table streamed through ONE
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      instr = vecs[i].instr;
      tick();
      chk("tbl_imm", imm_out, vecs[i].imm);
      chk("tbl_sel", 32'(ext_sel), 32'(vecs[i].sel));
      chk("tbl_ill", 32'(illegal), 32'(vecs[i].ill));
    end
    in_valid = 1'b0;
    tick();

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 2) != 0;
      flush     = ($urandom % 32) == 0;
      reset     = ($urandom % 128) == 0;
      r = $urandom;
      if (($urandom % 3) == 0) instr = r;
      else instr = {ops[$urandom % 11], r[25:0]};
      tick();
    end
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
